level_crossing_ctrl: RTL and testbench

//  Multi-track level-crossing controller: parametrised successor of the single-barrier crossing FSM.

---
 rtl/level_crossing_pkg.sv | 29 ++
 rtl/edge_detect_bank.sv | 23 ++
 rtl/level_crossing_ctrl.sv | 160 ++++++++++++++++
 tb/tb_level_crossing_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/level_crossing_pkg.sv
// Shared state encoding, barrier levels and sizing helper for the level-crossing controller.
package level_crossing_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_CAR = 3'd1;
  localparam logic [2:0] WARN     = 3'd2;
  localparam logic [2:0] LOWERING = 3'd3;
  localparam logic [2:0] DOWN     = 3'd4;
  localparam logic [2:0] RAISING  = 3'd5;

  localparam logic BARRIER_UP   = 1'b1;
  localparam logic BARRIER_DOWN = 1'b0;

  typedef enum logic [2:0] {
    StIdle     = IDLE,
    StWaitCar  = WAIT_CAR,
    StWarn     = WARN,
    StLowering = LOWERING,
    StDown     = DOWN,
    StRaising  = RAISING
  } state_e;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/edge_detect_bank.sv
// W-bit rising-edge detector; the delay register samples the input every clock.
module edge_detect_bank #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] re
);

  logic [W-1:0] d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q <= '0;
    end else begin
      d_q <= d;
    end
  end

  assign re = d & ~d_q;

endmodule

// File: rtl/level_crossing_ctrl.sv
// Multi-track level-crossing controller: per-track occupancy, warning lamp, timed barrier
// travel and a bounded wait for a car to clear the crossing.
module level_crossing_ctrl
  import level_crossing_pkg::*;
#(
  parameter int unsigned NUM_TRACKS    = 2,
  parameter int unsigned WARN_CYCLES   = 8,
  parameter int unsigned MOVE_CYCLES   = 4,
  parameter int unsigned CLEAR_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  car,
  input  logic [NUM_TRACKS-1:0] approach,
  input  logic [NUM_TRACKS-1:0] exit_s,
  input  logic                  fault_clr,
  output logic                  barrier_ctrl,
  output logic                  lamp,
  output logic [NUM_TRACKS-1:0] occupied,
  output logic                  fault
);

  localparam int unsigned CNT_W = $clog2(max3(WARN_CYCLES, MOVE_CYCLES, CLEAR_TIMEOUT) + 1);

  localparam logic [CNT_W-1:0] WarnLast  = CNT_W'(WARN_CYCLES - 1);
  localparam logic [CNT_W-1:0] MoveLast  = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ClearLast = CNT_W'(CLEAR_TIMEOUT - 1);

  logic [NUM_TRACKS-1:0] ap_re, ex_re;
  logic [NUM_TRACKS-1:0] occupied_d, occupied_q;
  logic                  fault_d, fault_q;
  logic                  occ_fault, timeout_fault;
  logic [CNT_W-1:0]      timer_d, timer_q;
  state_e                state_d, state_q;
  logic                  any_occ;

  edge_detect_bank #(.W(NUM_TRACKS)) u_approach_edge (
    .clk (clk),
    .rst (rst),
    .d   (approach),
    .re  (ap_re)
  );

  edge_detect_bank #(.W(NUM_TRACKS)) u_exit_edge (
    .clk (clk),
    .rst (rst),
    .d   (exit_s),
    .re  (ex_re)
  );

  // Simultaneous approach and exit on one track is a train passing straight through.
  always_comb begin
    occupied_d = occupied_q;
    occ_fault  = 1'b0;
    for (int i = 0; i < NUM_TRACKS; i++) begin
      if (ap_re[i] && !ex_re[i]) begin
        occupied_d[i] = 1'b1;
      end else if (ex_re[i] && !ap_re[i]) begin
        if (occupied_q[i]) begin
          occupied_d[i] = 1'b0;
        end else begin
          occ_fault = 1'b1;
        end
      end
    end
  end

  assign any_occ = |occupied_q;

  always_comb begin
    state_d       = state_q;
    timeout_fault = 1'b0;
    case (state_q)
      StIdle: begin
        if (any_occ) begin
          state_d = car ? StWaitCar : StWarn;
        end
      end
      StWaitCar: begin
        if (!any_occ) begin
          state_d = StIdle;
        end else if (!car) begin
          state_d = StWarn;
        end else if (timer_q == ClearLast) begin
          state_d       = StWarn;
          timeout_fault = 1'b1;
        end
      end
      StWarn: begin
        if (!any_occ) begin
          state_d = StIdle;
        end else if (timer_q == WarnLast) begin
          state_d = StLowering;
        end
      end
      StLowering: begin
        if (timer_q == MoveLast) begin
          state_d = StDown;
        end
      end
      StDown: begin
        if (!any_occ) begin
          state_d = StRaising;
        end
      end
      StRaising: begin
        if (any_occ) begin
          state_d = StLowering;
        end else if (timer_q == MoveLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Timer is free-running in untimed states; only the current state's limit is ever compared.
  always_comb begin
    timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;
  end

  // A set event in the same cycle as fault_clr keeps the flag set.
  always_comb begin
    if (occ_fault || timeout_fault) begin
      fault_d = 1'b1;
    end else if (fault_clr) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      occupied_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      occupied_q <= occupied_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    barrier_ctrl = BARRIER_UP;
    lamp         = 1'b1;
    case (state_q)
      StIdle:             lamp         = 1'b0;
      StLowering, StDown: barrier_ctrl = BARRIER_DOWN;
      default:            ;
    endcase
  end

  assign occupied = occupied_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_level_crossing_ctrl.sv
// Directed table-driven bench for level_crossing_ctrl plus hand sequences for timing corners.
module tb_level_crossing_ctrl;

  logic       clk;
  logic       rst;
  logic       car;
  logic [1:0] approach;
  logic [1:0] exit_s;
  logic       fault_clr;
  logic       barrier_ctrl;
  logic       lamp;
  logic [1:0] occupied;
  logic       fault;

  int checks = 0;
  int errors = 0;

  level_crossing_ctrl #(
    .NUM_TRACKS   (2),
    .WARN_CYCLES  (8),
    .MOVE_CYCLES  (4),
    .CLEAR_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .car          (car),
    .approach     (approach),
    .exit_s       (exit_s),
    .fault_clr    (fault_clr),
    .barrier_ctrl (barrier_ctrl),
    .lamp         (lamp),
    .occupied     (occupied),
    .fault        (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       car;
    logic [1:0] approach;
    logic [1:0] exit_s;
    logic       fault_clr;
    int         n;
    logic       barrier;
    logic       lamp;
    logic [1:0] occ;
    logic       fault;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input logic b, input logic l, input logic [1:0] o,
                         input logic f);
    chk({tag, " barrier"}, 8'(barrier_ctrl), 8'(b));
    chk({tag, " lamp"}, 8'(lamp), 8'(l));
    chk({tag, " occupied"}, 8'(occupied), 8'(o));
    chk({tag, " fault"}, 8'(fault), 8'(f));
  endtask

  initial begin
    // car, approach, exit_s, fault_clr, cycles, barrier, lamp, occupied, fault
    vecs[0]  = '{1'b0, 2'b01, 2'b00, 1'b0, 1, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[1]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 2'b00, 1'b0, 7, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1, 1'b0, 1'b1, 2'b01, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 2'b00, 1'b0, 3, 1'b0, 1'b1, 2'b01, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1, 1'b0, 1'b1, 2'b01, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 2'b00, 1'b0, 5, 1'b0, 1'b1, 2'b01, 1'b0};
    vecs[7]  = '{1'b0, 2'b00, 2'b01, 1'b0, 1, 1'b0, 1'b1, 2'b00, 1'b0};
    vecs[8]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1, 1'b1, 1'b1, 2'b00, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 2'b00, 1'b0, 3, 1'b1, 1'b1, 2'b00, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 2'b00, 1'b0, 1, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[11] = '{1'b0, 2'b00, 2'b10, 1'b0, 1, 1'b1, 1'b0, 2'b00, 1'b1};
    vecs[12] = '{1'b0, 2'b00, 2'b00, 1'b1, 1, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[13] = '{1'b0, 2'b00, 2'b10, 1'b1, 1, 1'b1, 1'b0, 2'b00, 1'b1};
    vecs[14] = '{1'b0, 2'b00, 2'b00, 1'b1, 1, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[15] = '{1'b0, 2'b01, 2'b01, 1'b0, 1, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[16] = '{1'b0, 2'b00, 2'b00, 1'b0, 2, 1'b1, 1'b0, 2'b00, 1'b0};

    rst       = 1'b0;
    car       = 1'b0;
    approach  = 2'b00;
    exit_s    = 2'b00;
    fault_clr = 1'b0;
    #12;
    chk_all("reset", 1'b1, 1'b0, 2'b00, 1'b0);
    rst = 1'b1;
    step(1);
    chk_all("post-reset", 1'b1, 1'b0, 2'b00, 1'b0);

    for (int i = 0; i < 17; i++) begin
      car       = vecs[i].car;
      approach  = vecs[i].approach;
      exit_s    = vecs[i].exit_s;
      fault_clr = vecs[i].fault_clr;
      step(vecs[i].n);
      chk_all($sformatf("vec%0d", i), vecs[i].barrier, vecs[i].lamp, vecs[i].occ, vecs[i].fault);
    end
    fault_clr = 1'b0;

    // Car blocks the crossing until the forced-close timeout.
    car = 1'b1;
    approach = 2'b10;
    step(1);
    chk_all("wc arrive", 1'b1, 1'b0, 2'b10, 1'b0);
    approach = 2'b00;
    step(1);
    chk_all("wc enter", 1'b1, 1'b1, 2'b10, 1'b0);
    step(15);
    chk_all("wc last", 1'b1, 1'b1, 2'b10, 1'b0);
    step(1);
    chk_all("wc timeout", 1'b1, 1'b1, 2'b10, 1'b1);
    fault_clr = 1'b1;
    step(1);
    chk("wc fault_clr", 8'(fault), 8'd0);
    fault_clr = 1'b0;
    car = 1'b0;
    exit_s = 2'b10;
    step(1);
    chk("wc exit occ", 8'(occupied), 8'd0);
    exit_s = 2'b00;
    step(1);
    chk_all("wc abort idle", 1'b1, 1'b0, 2'b00, 1'b0);

    // Car leaves after 5 cycles of waiting; WARN must then run its full length.
    car = 1'b1;
    approach = 2'b01;
    step(1);
    approach = 2'b00;
    step(1);
    step(4);
    car = 1'b0;
    step(1);
    chk_all("cl warn", 1'b1, 1'b1, 2'b01, 1'b0);
    step(7);
    chk("cl warn end", 8'(barrier_ctrl), 8'd1);
    step(1);
    chk_all("cl lowering", 1'b0, 1'b1, 2'b01, 1'b0);
    step(4);
    chk("mt down", 8'(barrier_ctrl), 8'd0);

    // Second train arrives while down; barrier holds until both tracks clear.
    approach = 2'b10;
    step(1);
    chk("mt occ both", 8'(occupied), 8'b11);
    approach = 2'b00;
    exit_s = 2'b01;
    step(1);
    exit_s = 2'b00;
    step(3);
    chk_all("mt one left", 1'b0, 1'b1, 2'b10, 1'b0);
    exit_s = 2'b10;
    step(1);
    chk_all("mt all clear", 1'b0, 1'b1, 2'b00, 1'b0);
    exit_s = 2'b00;
    step(1);
    chk("mt raising", 8'(barrier_ctrl), 8'd1);
    approach = 2'b01;
    step(1);
    chk_all("mt reapproach", 1'b1, 1'b1, 2'b01, 1'b0);
    approach = 2'b00;
    step(1);
    chk("mt relower", 8'(barrier_ctrl), 8'd0);
    exit_s = 2'b01;
    step(1);
    exit_s = 2'b00;
    step(2);
    chk("mt lower t3", 8'(barrier_ctrl), 8'd0);
    step(1);
    chk("mt down again", 8'(barrier_ctrl), 8'd0);
    step(1);
    chk("mt raise again", 8'(barrier_ctrl), 8'd1);
    step(3);
    chk("mt raise end", 8'(lamp), 8'd1);
    step(1);
    chk_all("mt idle", 1'b1, 1'b0, 2'b00, 1'b0);

    // Asynchronous reset while lowering.
    approach = 2'b01;
    step(1);
    approach = 2'b00;
    step(9);
    chk("rs lowering", 8'(barrier_ctrl), 8'd0);
    #2;
    rst = 1'b0;
    #1;
    chk_all("rs async", 1'b1, 1'b0, 2'b00, 1'b0);
    #3;
    rst = 1'b1;
    step(2);
    chk_all("rs idle", 1'b1, 1'b0, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
